// File: rtl/crc_seq_ctrl.sv
// Byte sequencer for the lfsrN CRC engine: loads the engine, serialises each
// accepted byte into 8 single-bit shifts and presents the masked, XORed result.
module crc_seq_ctrl #(
  parameter int WIDTH     = 32,
  parameter int BIT_COUNT = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 finish_i,
  input  logic                 byte_valid_i,
  input  logic [7:0]           byte_data_i,
  output logic                 byte_ready_o,
  input  logic                 lsb_first_i,
  input  logic [BIT_COUNT-1:0] bitwidth_i,
  input  logic [WIDTH-1:0]     xor_out_i,
  input  logic [WIDTH-1:0]     lfsr_value_i,
  output logic                 lfsr_load_o,
  output logic                 lfsr_shift_o,
  output logic                 lfsr_data_o,
  output logic                 busy_o,
  output logic                 crc_valid_o,
  output logic [WIDTH-1:0]     crc_out_o,
  output logic [2:0]           state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_READY = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t     state_q;
  logic [2:0] cnt_q;
  logic [7:0] buf_q;
  logic       lsb_q;
  logic [WIDTH-1:0] mask;

  // Handshake: a byte transfers on a rising edge where byte_valid_i and
  // byte_ready_o are both high; byte_ready_o is only ever high in READY and
  // the source must hold byte_data_i/lsb_first_i stable until that edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      buf_q   <= 8'd0;
      lsb_q   <= 1'b0;
    end else if (start_i) begin
      state_q <= S_LOAD;
      cnt_q   <= 3'd0;
    end else begin
      case (state_q)
        S_LOAD:  state_q <= S_READY;
        S_READY: begin
          // A byte beats a simultaneous finish; the source re-asserts finish.
          if (byte_valid_i) begin
            buf_q   <= byte_data_i;
            lsb_q   <= lsb_first_i;
            cnt_q   <= 3'd0;
            state_q <= S_SHIFT;
          end else if (finish_i) begin
            state_q <= S_DONE;
          end
        end
        S_SHIFT: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_q <= S_READY;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i <= int'(bitwidth_i)) mask[i] = 1'b1;
    end
  end

  assign lfsr_load_o  = (state_q == S_LOAD);
  assign lfsr_shift_o = (state_q == S_SHIFT);
  assign lfsr_data_o  = (state_q == S_SHIFT) &&
                        (lsb_q ? buf_q[cnt_q] : buf_q[3'd7 - cnt_q]);
  assign byte_ready_o = (state_q == S_READY);
  assign busy_o       = (state_q == S_LOAD) || (state_q == S_SHIFT) ||
                        (state_q == S_DONE);
  assign crc_valid_o  = (state_q == S_DONE);
  assign crc_out_o    = (state_q == S_DONE) ? ((lfsr_value_i ^ xor_out_i) & mask)
                                            : '0;
  assign state_o      = state_q;

endmodule

// File: tb/tb_crc_seq_ctrl.sv
// Self-checking bench for crc_seq_ctrl: shifted bits and CRC results are
// predicted into queues when stimulus is driven and compared as they appear.
module tb_crc_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, finish, byte_valid, lsb_first;
  logic [7:0]  byte_data;
  logic [4:0]  bitwidth;
  logic [31:0] xor_out, lfsr_value;
  logic        byte_ready, lfsr_load, lfsr_shift, lfsr_data, busy, crc_valid;
  logic [31:0] crc_out;
  logic [2:0]  state;

  logic [0:0]  exp_bit_q[$];
  logic [31:0] exp_crc_q[$];
  int n_chk = 0, n_pass = 0, shift_cnt = 0, crc_cnt = 0;

  crc_seq_ctrl #(.WIDTH(32), .BIT_COUNT(5)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .finish_i(finish),
    .byte_valid_i(byte_valid), .byte_data_i(byte_data), .byte_ready_o(byte_ready),
    .lsb_first_i(lsb_first), .bitwidth_i(bitwidth), .xor_out_i(xor_out),
    .lfsr_value_i(lfsr_value), .lfsr_load_o(lfsr_load), .lfsr_shift_o(lfsr_shift),
    .lfsr_data_o(lfsr_data), .busy_o(busy), .crc_valid_o(crc_valid),
    .crc_out_o(crc_out), .state_o(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bits(input logic [7:0] b, input logic lsb, input int n);
    for (int i = 0; i < n; i++) exp_bit_q.push_back(lsb ? b[i] : b[7-i]);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  // scoreboard: compare every shifted bit and every result strobe
  always @(negedge clk) begin
    if (lfsr_shift === 1'b1) begin
      shift_cnt++;
      if (exp_bit_q.size() == 0) check("shift_unexpected", 32'd1, 32'd0);
      else check("lfsr_data", {31'd0, lfsr_data}, {31'd0, exp_bit_q.pop_front()});
    end
    if (crc_valid === 1'b1) begin
      crc_cnt++;
      if (exp_crc_q.size() == 0) check("crc_unexpected", 32'd1, 32'd0);
      else check("crc_out", crc_out, exp_crc_q.pop_front());
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; finish = 1'b1; byte_valid = 1'b1;
    byte_data = 8'h00; lsb_first = 1'b0; bitwidth = 5'd31;
    xor_out = 32'h0; lfsr_value = 32'h0;

    // reset and idle: byte_valid/finish ignored
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_outputs", {26'd0, byte_ready, lfsr_load, lfsr_shift, busy, crc_valid, lfsr_data}, 32'd0);
      check("idle_crc_out", crc_out, 32'd0);
    end
    byte_valid = 1'b0; finish = 1'b0;

    // MSB-first 0x1D
    start = 1'b1;
    tick();
    start = 1'b0;
    check("load_pulse", {30'd0, lfsr_load, byte_ready}, 32'd2);
    tick();
    check("load_one_cycle", {30'd0, lfsr_load, byte_ready}, 32'd1);
    byte_data = 8'h1D; lsb_first = 1'b0; byte_valid = 1'b1;
    push_bits(8'h1D, 1'b0, 8);
    tick();
    byte_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("msb_shift_window", {30'd0, lfsr_shift, byte_ready}, 32'd2);
      tick();
    end
    check("ready_after_9", {30'd0, lfsr_shift, byte_ready}, 32'd1);

    // LSB-first back-to-back 0x1D, 0x80
    byte_data = 8'h1D; lsb_first = 1'b1; byte_valid = 1'b1;
    push_bits(8'h1D, 1'b1, 8);
    tick();
    byte_data = 8'h80;
    push_bits(8'h80, 1'b1, 8);
    for (int i = 0; i < 8; i++) begin
      check("lsb_shift_window", {30'd0, lfsr_shift, byte_ready}, 32'd2);
      tick();
    end
    check("second_accept_at_9", {31'd0, byte_ready}, 32'd1);
    tick();
    byte_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("shift_total_24", shift_cnt, 32'd24);
    check("bits_drained", exp_bit_q.size(), 32'd0);

    // result masking, bitwidth 7
    lfsr_value = 32'hFFFFFF3C; xor_out = 32'h000000FF; bitwidth = 5'd7;
    finish = 1'b1;
    exp_crc_q.push_back(32'h000000C3);
    tick();
    finish = 1'b0;
    check("done_strobe", {30'd0, crc_valid, busy}, 32'd3);
    tick();
    check("after_done", {30'd0, crc_valid, busy}, 32'd0);
    check("crc_out_zero", crc_out, 32'd0);

    // result masking, bitwidth 31
    do_start();
    bitwidth = 5'd31;
    finish = 1'b1;
    exp_crc_q.push_back(32'hFFFFFFC3);
    tick();
    finish = 1'b0;
    tick();
    check("crc_count_2", crc_cnt, 32'd2);

    // finish together with byte_valid: byte wins
    do_start();
    byte_data = 8'hA5; lsb_first = 1'b0; byte_valid = 1'b1; finish = 1'b1;
    push_bits(8'hA5, 1'b0, 8);
    tick();
    byte_valid = 1'b0; finish = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("collide_ready", {30'd0, byte_ready, busy}, 32'd2);
    check("collide_no_crc", crc_cnt, 32'd2);

    // start during the 4th shift cycle
    byte_data = 8'h3C; lsb_first = 1'b0; byte_valid = 1'b1;
    push_bits(8'h3C, 1'b0, 4);
    tick();
    byte_valid = 1'b0;
    tick(); tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_load", {30'd0, lfsr_load, lfsr_shift}, 32'd2);
    tick();
    check("restart_ready", {30'd0, byte_ready, lfsr_shift}, 32'd2);

    // reset mid-SHIFT
    byte_data = 8'h55; lsb_first = 1'b0; byte_valid = 1'b1;
    push_bits(8'h55, 1'b0, 2);
    tick();
    byte_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_abort", {29'd0, lfsr_shift, busy, byte_ready}, 32'd0);
    tick(); tick();
    check("rst_state_idle", {29'd0, state}, 32'd0);

    check("shift_total_38", shift_cnt, 32'd38);
    check("bits_left", exp_bit_q.size(), 32'd0);
    check("crc_left", exp_crc_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
